// File: rtl/apb_to_obi.sv
// apb_to_obi: APB slave to OBI manager bridge, one transfer outstanding.
//   clk_i, rst_ni                  : clock, synchronous active-low reset
//   psel_i/penable_i/pwrite_i      : APB control
//   paddr_i/pwdata_i/pstrb_i       : APB address, write data, strobes
//   pprot_i                        : APB protection (ignored)
//   prdata_o/pready_o/pslverr_o    : APB response, register-driven
//   req_o/gnt_i                    : OBI request handshake
//   addr_o/we_o/be_o/wdata_o       : OBI request payload (held registers)
//   rvalid_i/rdata_i/err_i         : OBI response
//   rready_o                       : OBI response ready, always 1
module apb_to_obi #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   localparam int unsigned StrbWidth = DataWidth / 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 psel_i,
   input  logic                 penable_i,
   input  logic                 pwrite_i,
   input  logic [AddrWidth-1:0] paddr_i,
   input  logic [DataWidth-1:0] pwdata_i,
   input  logic [StrbWidth-1:0] pstrb_i,
   input  logic [2:0]           pprot_i,
   output logic [DataWidth-1:0] prdata_o,
   output logic                 pready_o,
   output logic                 pslverr_o,
   output logic                 req_o,
   input  logic                 gnt_i,
   output logic [AddrWidth-1:0] addr_o,
   output logic                 we_o,
   output logic [StrbWidth-1:0] be_o,
   output logic [DataWidth-1:0] wdata_o,
   input  logic                 rvalid_i,
   input  logic [DataWidth-1:0] rdata_i,
   input  logic                 err_i,
   output logic                 rready_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic                 we;
      logic [StrbWidth-1:0] be;
      logic [DataWidth-1:0] wdata;
   } obi_req_t;

   state_e               state_q, state_d;
   obi_req_t             obi_q, obi_d;
   logic [DataWidth-1:0] rdata_q, rdata_d;
   logic                 err_q, err_d;

   // Protection attributes have no OBI counterpart.
   logic unused_pprot;
   assign unused_pprot = ^pprot_i;

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Captured request payload and response.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         obi_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         obi_q   <= obi_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next-state and capture logic.
   always_comb begin
      state_d = state_q;
      obi_d   = obi_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (psel_i) begin
               obi_d.addr  = paddr_i;
               obi_d.we    = pwrite_i;
               // Reads fetch the full word.
               obi_d.be    = pwrite_i ? pstrb_i : {StrbWidth{1'b1}};
               obi_d.wdata = pwdata_i;
               state_d     = REQ;
            end
         end
         REQ: begin
            if (gnt_i) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (rvalid_i) begin
               // Writes return zero so no stale read data leaks onto prdata.
               rdata_d = obi_q.we ? '0 : rdata_i;
               err_d   = err_i;
               state_d = DONE;
            end
         end
         DONE: begin
            if (psel_i && penable_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded purely from registers; gnt/rvalid never reach APB combinationally.
   assign req_o     = (state_q == REQ);
   assign addr_o    = obi_q.addr;
   assign we_o      = obi_q.we;
   assign be_o      = obi_q.be;
   assign wdata_o   = obi_q.wdata;
   assign rready_o  = 1'b1;
   assign pready_o  = (state_q == DONE);
   assign pslverr_o = (state_q == DONE) && err_q;
   assign prdata_o  = (state_q == DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_apb_to_obi.sv
// tb_apb_to_obi: directed and randomized transfers against a cycle-accurate
// transaction model (latency = 3 + grant wait + response wait).
module tb_apb_to_obi;

   logic        clk;
   logic        rst_n;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        req, gnt, we, rvalid, err, rready;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be;

   int tests  = 0;
   int failed = 0;

   apb_to_obi #(.AddrWidth(32), .DataWidth(32)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .psel_i   (psel),
      .penable_i(penable),
      .pwrite_i (pwrite),
      .paddr_i  (paddr),
      .pwdata_i (pwdata),
      .pstrb_i  (pstrb),
      .pprot_i  (pprot),
      .prdata_o (prdata),
      .pready_o (pready),
      .pslverr_o(pslverr),
      .req_o    (req),
      .gnt_i    (gnt),
      .addr_o   (addr),
      .we_o     (we),
      .be_o     (be),
      .wdata_o  (wdata),
      .rvalid_i (rvalid),
      .rdata_i  (rdata),
      .err_i    (err),
      .rready_o (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full APB transfer starting at a negedge with the DUT idle; returns at the
   // negedge of the idle cycle that follows completion.
   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input int gd, input int rd,
                       input logic [31:0] rdat, input logic er, input logic stray);
      int          done_cyc;
      logic [31:0] exp_rd;
      logic [3:0]  exp_be;
      done_cyc = 3 + gd + rd;
      exp_rd   = wr ? 32'h0 : rdat;
      exp_be   = wr ? st : 4'hF;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
      pprot = 3'($urandom);
      gnt = 1'b0; rvalid = 1'b0;
      for (int c = 1; c <= done_cyc + 1; c++) begin
         @(negedge clk);
         penable = 1'b1;
         chk("req",     64'(req),     64'(c <= 1 + gd));
         chk("addr",    64'(addr),    64'(a));
         chk("we",      64'(we),      64'(wr));
         chk("be",      64'(be),      64'(exp_be));
         chk("wdata",   64'(wdata),   64'(wd));
         chk("pready",  64'(pready),  64'(c == done_cyc));
         chk("prdata",  64'(prdata),  (c == done_cyc) ? 64'(exp_rd) : 64'h0);
         chk("pslverr", 64'(pslverr), (c == done_cyc) ? 64'(er) : 64'h0);
         gnt    = (c == 1 + gd);
         rvalid = (c == 2 + gd + rd);
         // Responses seen while still requesting must be ignored.
         if (stray && c <= 1 + gd) rvalid = 1'($urandom);
         if (c == 2 + gd + rd) begin
            rdata = rdat; err = er;
         end else begin
            rdata = $urandom; err = 1'($urandom);
         end
         if (c == done_cyc + 1) begin
            gnt = 1'b0; rvalid = 1'b0; psel = 1'b0; penable = 1'b0;
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req"},     64'(req),     64'h0);
      chk({tag, "_pready"},  64'(pready),  64'h0);
      chk({tag, "_pslverr"}, 64'(pslverr), 64'h0);
      chk({tag, "_prdata"},  64'(prdata),  64'h0);
      chk({tag, "_addr"},    64'(addr),    64'h0);
      chk({tag, "_we"},      64'(we),      64'h0);
      chk({tag, "_be"},      64'(be),      64'h0);
      chk({tag, "_wdata"},   64'(wdata),   64'h0);
      chk({tag, "_rready"},  64'(rready),  64'h1);
   endtask

   initial begin
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
      gnt = 1'b0; rvalid = 1'b0; rdata = '0; err = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;

      // Write, immediate grant and response.
      xfer(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'h3, 0, 0, 32'hFFFF_0000, 1'b0, 1'b0);
      // Read, response three cycles after grant.
      xfer(1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 2, 32'h1234_5678, 1'b0, 1'b0);
      // Grant stall of four cycles.
      xfer(1'b1, 32'hA5A5_0010, 32'h0BAD_F00D, 4'hC, 4, 0, 32'h0, 1'b0, 1'b0);
      // Error response, then a clean transfer.
      xfer(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1, 1, 32'hCAFE_0001, 1'b1, 1'b0);
      xfer(1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 0, 32'hCAFE_0002, 1'b0, 1'b0);

      // Reset while waiting for the response; later rvalid must be ignored.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0080; pstrb = 4'h0;
      @(negedge clk);
      penable = 1'b1; gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      chk("resp_req", 64'(req), 64'h0);
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      chk_zero("midrst");
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rvalid = 1'b1; rdata = $urandom; err = 1'b1;
         @(negedge clk);
         chk("stray_pready",  64'(pready),  64'h0);
         chk("stray_pslverr", 64'(pslverr), 64'h0);
         chk("stray_req",     64'(req),     64'h0);
      end
      rvalid = 1'b0; err = 1'b0;

      // Back-to-back read then write: the write must not carry the read data.
      xfer(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 1, 32'h8765_4321, 1'b0, 1'b0);
      xfer(1'b1, 32'h0000_0104, 32'h1111_2222, 4'hF, 1, 0, 32'h9999_9999, 1'b0, 1'b0);

      // Randomized transfers with random waits, strays and idle gaps.
      for (int n = 0; n < 30; n++) begin
         xfer(1'($urandom), $urandom, $urandom, 4'($urandom),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              $urandom, 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            repeat (int'($urandom_range(1, 3))) begin
               @(negedge clk);
               chk("gap_pready", 64'(pready), 64'h0);
               chk("gap_req",    64'(req),    64'h0);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
